// File: rtl/csr_exc_unit.sv
// ---------------------------------------------------------------------------
// csr_exc_unit
//
// This block holds the LoongArch exception, interrupt, scratch and timer CSRs.
// It answers CSR reads and masked writes coming from the write-back stage.
// It commits the state changes for an exception or an ertn when WB signals
// one, and it returns the exception entry, the ERA and the pending-interrupt
// flag to the fetch end of the pipeline.
//
// Ports
//   clk, resetn            clock, asynchronous active-low reset
//   csr_re                 read strobe (reads are always combinational)
//   csr_num                CSR number for both read and write
//   csr_rvalue             read data, 0 for unmapped numbers
//   csr_we/wmask/wvalue    masked write from WB
//   wb_ex/ecode/esubcode   exception commit with its cause
//   wb_pc, wb_vaddr        excepting PC and faulting data address
//   ertn_flush             ertn commit
//   hw_int_in, ipi_int_in  level-sensitive interrupt lines
//   ex_entry, ertn_era     EENTRY and ERA to the front end
//   has_int                an enabled interrupt is pending
// ---------------------------------------------------------------------------
module csr_exc_unit #(
    parameter int TIMER_W = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        csr_re,
    input  logic [13:0] csr_num,
    output logic [31:0] csr_rvalue,
    input  logic        csr_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    input  logic        wb_ex,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_vaddr,
    input  logic        ertn_flush,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic [31:0] ex_entry,
    output logic [31:0] ertn_era,
    output logic        has_int
);

    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ECFG   = 14'h004;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_BADV   = 14'h007;
    localparam logic [13:0] CSR_EENTRY = 14'h00C;
    localparam logic [13:0] CSR_SAVE0  = 14'h030;
    localparam logic [13:0] CSR_SAVE1  = 14'h031;
    localparam logic [13:0] CSR_SAVE2  = 14'h032;
    localparam logic [13:0] CSR_SAVE3  = 14'h033;
    localparam logic [13:0] CSR_TID    = 14'h040;
    localparam logic [13:0] CSR_TCFG   = 14'h041;
    localparam logic [13:0] CSR_TVAL   = 14'h042;
    localparam logic [13:0] CSR_TICLR  = 14'h044;

    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;

    // LIE bit 10 does not exist; it is kept out of the register entirely.
    localparam logic [12:0] LIE_MASK = 13'h1BFF;

    localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);

    // csr_re only qualifies reads upstream; the read port is always live.
    logic unused_csr_re;
    assign unused_csr_re = csr_re;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic [4:0]         crmd_q,        crmd_d;
    logic [2:0]         prmd_q,        prmd_d;
    logic [12:0]        ecfg_lie_q,    ecfg_lie_d;
    logic [1:0]         estat_sw_q,    estat_sw_d;
    logic [7:0]         estat_hw_q,    estat_hw_d;
    logic               estat_ti_q,    estat_ti_d;
    logic               estat_ipi_q,   estat_ipi_d;
    logic [5:0]         estat_ecode_q, estat_ecode_d;
    logic [8:0]         estat_esub_q,  estat_esub_d;
    logic [31:0]        era_q,         era_d;
    logic [31:0]        badv_q,        badv_d;
    logic [25:0]        eentry_q,      eentry_d;
    logic [3:0][31:0]   save_q,        save_d;
    logic [31:0]        tid_q,         tid_d;
    logic [TIMER_W-1:0] tcfg_q,        tcfg_d;
    logic [TIMER_W-1:0] tval_q,        tval_d;

    logic [12:0] estat_is;
    logic [31:0] rd_word;
    logic [31:0] wr_word;
    logic        wr_active;
    logic        tcfg_wr;
    logic        ticlr_hit;
    logic        timer_fire;

    function automatic logic [31:0] timer_ext(input logic [TIMER_W-1:0] v);
        logic [31:0] r;
        r = '0;
        r[TIMER_W-1:0] = v;
        return r;
    endfunction

    assign estat_is = {estat_ipi_q, estat_ti_q, 1'b0, estat_hw_q, estat_sw_q};

    // -----------------------------------------------------------------------
    // Read mux
    // -----------------------------------------------------------------------
    always_comb begin
        rd_word = 32'h0;
        case (csr_num)
            CSR_CRMD:   rd_word = {27'h0, crmd_q};
            CSR_PRMD:   rd_word = {29'h0, prmd_q};
            CSR_ECFG:   rd_word = {19'h0, ecfg_lie_q};
            CSR_ESTAT:  rd_word = {1'b0, estat_esub_q, estat_ecode_q, 3'b000, estat_is};
            CSR_ERA:    rd_word = era_q;
            CSR_BADV:   rd_word = badv_q;
            CSR_EENTRY: rd_word = {eentry_q, 6'h00};
            CSR_SAVE0:  rd_word = save_q[0];
            CSR_SAVE1:  rd_word = save_q[1];
            CSR_SAVE2:  rd_word = save_q[2];
            CSR_SAVE3:  rd_word = save_q[3];
            CSR_TID:    rd_word = tid_q;
            CSR_TCFG:   rd_word = timer_ext(tcfg_q);
            CSR_TVAL:   rd_word = timer_ext(tval_q);
            default:    rd_word = 32'h0;
        endcase
    end

    assign csr_rvalue = rd_word;

    // The merged word starts from the current read value of the addressed
    // CSR; each register then takes only its writable bits from it, so RO
    // and always-zero bits can never be disturbed by a write.
    assign wr_word   = (rd_word & ~csr_wmask) | (csr_wvalue & csr_wmask);

    // Exception and ertn commits take precedence and swallow a same-cycle write.
    assign wr_active = csr_we & ~wb_ex & ~ertn_flush;
    assign tcfg_wr   = wr_active & (csr_num == CSR_TCFG);
    assign ticlr_hit = wr_active & (csr_num == CSR_TICLR) & csr_wmask[0] & csr_wvalue[0];

    // -----------------------------------------------------------------------
    // Next-state for the architectural CSRs
    // -----------------------------------------------------------------------
    always_comb begin
        crmd_d        = crmd_q;
        prmd_d        = prmd_q;
        ecfg_lie_d    = ecfg_lie_q;
        estat_sw_d    = estat_sw_q;
        estat_ecode_d = estat_ecode_q;
        estat_esub_d  = estat_esub_q;
        era_d         = era_q;
        badv_d        = badv_q;
        eentry_d      = eentry_q;
        save_d        = save_q;
        tid_d         = tid_q;
        tcfg_d        = tcfg_q;

        if (wb_ex) begin
            prmd_d        = crmd_q[2:0];
            crmd_d[2:0]   = 3'b000;
            estat_ecode_d = wb_ecode;
            estat_esub_d  = wb_esubcode;
            era_d         = wb_pc;
            if (wb_ecode == ECODE_ADEF) begin
                badv_d = wb_pc;
            end else if (wb_ecode == ECODE_ALE) begin
                badv_d = wb_vaddr;
            end
        end else if (ertn_flush) begin
            crmd_d[2:0] = prmd_q;
        end else if (wr_active) begin
            case (csr_num)
                CSR_CRMD:   crmd_d     = wr_word[4:0];
                CSR_PRMD:   prmd_d     = wr_word[2:0];
                CSR_ECFG:   ecfg_lie_d = wr_word[12:0] & LIE_MASK;
                CSR_ESTAT:  estat_sw_d = wr_word[1:0];
                CSR_ERA:    era_d      = wr_word;
                CSR_BADV:   badv_d     = wr_word;
                CSR_EENTRY: eentry_d   = wr_word[31:6];
                CSR_SAVE0:  save_d[0]  = wr_word;
                CSR_SAVE1:  save_d[1]  = wr_word;
                CSR_SAVE2:  save_d[2]  = wr_word;
                CSR_SAVE3:  save_d[3]  = wr_word;
                CSR_TID:    tid_d      = wr_word;
                CSR_TCFG:   tcfg_d     = wr_word[TIMER_W-1:0];
                default:    ;
            endcase
        end
    end

    // Interrupt lines are level-sensitive and simply resampled every cycle.
    assign estat_hw_d  = hw_int_in;
    assign estat_ipi_d = ipi_int_in;

    // -----------------------------------------------------------------------
    // Timer: down-counter with terminal-count flag
    // -----------------------------------------------------------------------
    always_comb begin
        tval_d     = tval_q;
        timer_fire = 1'b0;
        if (tcfg_wr && tcfg_d[0]) begin
            // Enabling write restarts the count from the freshly written InitVal.
            tval_d = {tcfg_d[TIMER_W-1:2], 2'b00};
        end else if (tcfg_q[0]) begin
            if (tval_q != '0) begin
                tval_d     = tval_q - TIMER_ONE;
                timer_fire = (tval_q == TIMER_ONE);
            end else if (tcfg_q[1]) begin
                tval_d = {tcfg_q[TIMER_W-1:2], 2'b00};
            end
        end
    end

    // A terminal count in the same cycle as a clear keeps the flag set.
    always_comb begin
        estat_ti_d = estat_ti_q;
        if (timer_fire) begin
            estat_ti_d = 1'b1;
        end else if (ticlr_hit) begin
            estat_ti_d = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // State flops
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            crmd_q        <= 5'b01000;
            prmd_q        <= '0;
            ecfg_lie_q    <= '0;
            estat_sw_q    <= '0;
            estat_hw_q    <= '0;
            estat_ti_q    <= 1'b0;
            estat_ipi_q   <= 1'b0;
            estat_ecode_q <= '0;
            estat_esub_q  <= '0;
            era_q         <= '0;
            badv_q        <= '0;
            eentry_q      <= '0;
            save_q        <= '0;
            tid_q         <= '0;
            tcfg_q        <= '0;
            tval_q        <= '1;
        end else begin
            crmd_q        <= crmd_d;
            prmd_q        <= prmd_d;
            ecfg_lie_q    <= ecfg_lie_d;
            estat_sw_q    <= estat_sw_d;
            estat_hw_q    <= estat_hw_d;
            estat_ti_q    <= estat_ti_d;
            estat_ipi_q   <= estat_ipi_d;
            estat_ecode_q <= estat_ecode_d;
            estat_esub_q  <= estat_esub_d;
            era_q         <= era_d;
            badv_q        <= badv_d;
            eentry_q      <= eentry_d;
            save_q        <= save_d;
            tid_q         <= tid_d;
            tcfg_q        <= tcfg_d;
            tval_q        <= tval_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs to the front end
    // -----------------------------------------------------------------------
    assign ex_entry = {eentry_q, 6'h00};
    assign ertn_era = era_q;
    assign has_int  = crmd_q[2] & (|(estat_is & ecfg_lie_q));

endmodule

// File: tb/tb_csr_exc_unit.sv
// Self-checking bench for csr_exc_unit: directed scenarios with constant
// expectations, then a randomized run checked against a CSR-array model.
module tb_csr_exc_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic [31:0] wb_vaddr;
    logic        ertn_flush;
    logic [7:0]  hw_int_in;
    logic        ipi_int_in;
    logic [31:0] ex_entry;
    logic [31:0] ertn_era;
    logic        has_int;

    int total = 0;
    int bad   = 0;

    // Model: one 32-bit readable image per CSR number below 128.
    logic [31:0] m [0:127];

    csr_exc_unit #(.TIMER_W(32)) dut (
        .clk(clk), .resetn(resetn), .csr_re(csr_re), .csr_num(csr_num),
        .csr_rvalue(csr_rvalue), .csr_we(csr_we), .csr_wmask(csr_wmask),
        .csr_wvalue(csr_wvalue), .wb_ex(wb_ex), .wb_ecode(wb_ecode),
        .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
        .ertn_flush(ertn_flush), .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in),
        .ex_entry(ex_entry), .ertn_era(ertn_era), .has_int(has_int)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] wr_mask(input int n);
        case (n)
            'h00: return 32'h0000_001F;
            'h01: return 32'h0000_0007;
            'h04: return 32'h0000_1BFF;
            'h05: return 32'h0000_0003;
            'h06, 'h07, 'h30, 'h31, 'h32, 'h33, 'h40, 'h41: return 32'hFFFF_FFFF;
            'h0C: return 32'hFFFF_FFC0;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 128; i++) m[i] = 32'h0;
        m['h00] = 32'h8;
        m['h42] = 32'hFFFF_FFFF;
    endtask

    task automatic model_step();
        logic [31:0] old_tcfg, old_tval, msk;
        bit en_wr, fire, clr;
        old_tcfg = m['h41];
        old_tval = m['h42];
        en_wr = 0; fire = 0; clr = 0;
        if (wb_ex) begin
            m['h01] = {29'd0, m['h00][2:0]};
            m['h00] = m['h00] & ~32'h7;
            m['h05] = {1'b0, wb_esubcode, wb_ecode, m['h05][15:0]};
            m['h06] = wb_pc;
            if (wb_ecode == 6'h08) m['h07] = wb_pc;
            else if (wb_ecode == 6'h09) m['h07] = wb_vaddr;
        end else if (ertn_flush) begin
            m['h00] = (m['h00] & ~32'h7) | (m['h01] & 32'h7);
        end else if (csr_we) begin
            if (csr_num < 14'd128) begin
                msk = csr_wmask & wr_mask(int'(csr_num));
                m[csr_num[6:0]] = (m[csr_num[6:0]] & ~msk) | (csr_wvalue & msk);
            end
            if (csr_num == 14'h41 && m['h41][0]) en_wr = 1;
            if (csr_num == 14'h44 && csr_wvalue[0] && csr_wmask[0]) clr = 1;
        end
        if (en_wr) begin
            m['h42] = m['h41] & ~32'h3;
        end else if (old_tcfg[0]) begin
            if (old_tval != 0) begin
                m['h42] = old_tval - 1;
                fire = (old_tval == 1);
            end else if (old_tcfg[1]) begin
                m['h42] = old_tcfg & ~32'h3;
            end
        end
        if (fire) m['h05][11] = 1'b1;
        else if (clr) m['h05][11] = 1'b0;
        m['h05][9:2] = hw_int_in;
        m['h05][12]  = ipi_int_in;
    endtask

    // One clock: the model advances on the same edge, strobes drop after it.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        csr_we = 0; wb_ex = 0; ertn_flush = 0;
    endtask

    task automatic do_write(input logic [13:0] n, input logic [31:0] v, input logic [31:0] mk);
        csr_num = n; csr_wvalue = v; csr_wmask = mk; csr_we = 1;
        tick();
    endtask

    task automatic test_reset();
        logic [13:0] nums [8];
        logic [31:0] exps [8];
        nums = '{14'h0, 14'h1, 14'h4, 14'h5, 14'h6, 14'hC, 14'h41, 14'h42};
        exps = '{32'h8, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF};
        for (int i = 0; i < 8; i++) begin
            csr_num = nums[i];
            #1;
            total++;
            if (csr_rvalue !== exps[i]) begin
                bad++;
                $display("FAIL reset_csr_%0h got=%h exp=%h", nums[i], csr_rvalue, exps[i]);
            end
        end
        total++;
        if (has_int !== 1'b0) begin bad++; $display("FAIL reset_has_int got=%b exp=0", has_int); end
        total++;
        if (ex_entry !== 32'h0) begin bad++; $display("FAIL reset_ex_entry got=%h exp=0", ex_entry); end
    endtask

    task automatic test_eentry();
        do_write(14'hC, 32'h1C00_8FFF, 32'hFFFF_FFFF);
        csr_num = 14'hC; #1;
        total++;
        if (csr_rvalue !== 32'h1C00_8FC0) begin bad++; $display("FAIL eentry_read got=%h exp=1c008fc0", csr_rvalue); end
        total++;
        if (ex_entry !== 32'h1C00_8FC0) begin bad++; $display("FAIL ex_entry got=%h exp=1c008fc0", ex_entry); end
    endtask

    task automatic test_ex_ertn();
        do_write(14'h0, 32'h7, 32'hFFFF_FFFF);
        wb_ex = 1; wb_ecode = 6'h0B; wb_esubcode = 9'h0; wb_pc = 32'h1C00_0100;
        tick();
        csr_num = 14'h0; #1;
        total++;
        if (csr_rvalue !== 32'h0) begin bad++; $display("FAIL ex_crmd got=%h exp=0", csr_rvalue); end
        csr_num = 14'h1; #1;
        total++;
        if (csr_rvalue !== 32'h7) begin bad++; $display("FAIL ex_prmd got=%h exp=7", csr_rvalue); end
        total++;
        if (ertn_era !== 32'h1C00_0100) begin bad++; $display("FAIL ex_era got=%h exp=1c000100", ertn_era); end
        csr_num = 14'h5; #1;
        total++;
        if (csr_rvalue[21:16] !== 6'h0B) begin bad++; $display("FAIL ex_ecode got=%h exp=0b", csr_rvalue[21:16]); end
        ertn_flush = 1;
        tick();
        csr_num = 14'h0; #1;
        total++;
        if (csr_rvalue !== 32'h7) begin bad++; $display("FAIL ertn_crmd got=%h exp=7", csr_rvalue); end
    endtask

    task automatic test_badv_priority();
        wb_ex = 1; wb_ecode = 6'h09; wb_esubcode = 9'h0; wb_pc = 32'h1C00_0200; wb_vaddr = 32'h0000_1003;
        csr_we = 1; csr_num = 14'h7; csr_wvalue = 32'hDEAD; csr_wmask = 32'hFFFF_FFFF;
        tick();
        csr_num = 14'h7; #1;
        total++;
        if (csr_rvalue !== 32'h0000_1003) begin bad++; $display("FAIL badv_ale got=%h exp=00001003", csr_rvalue); end
    endtask

    task automatic test_timer_oneshot();
        do_write(14'h41, 32'h0000_000D, 32'hFFFF_FFFF);
        csr_num = 14'h42; #1;
        total++;
        if (csr_rvalue !== 32'd12) begin bad++; $display("FAIL oneshot_load got=%0d exp=12", csr_rvalue); end
        for (int i = 11; i >= -3; i--) begin
            tick();
            csr_num = 14'h42; #1;
            total++;
            if (csr_rvalue !== ((i < 0) ? 32'd0 : 32'(i))) begin
                bad++; $display("FAIL oneshot_tval got=%0d exp=%0d", csr_rvalue, (i < 0) ? 0 : i);
            end
            csr_num = 14'h5; #1;
            total++;
            if (csr_rvalue[11] !== (i <= 0)) begin
                bad++; $display("FAIL oneshot_flag step=%0d got=%b exp=%b", i, csr_rvalue[11], (i <= 0));
            end
        end
        do_write(14'h44, 32'h1, 32'h1);
        tick();
        csr_num = 14'h5; #1;
        total++;
        if (csr_rvalue[11] !== 1'b0) begin bad++; $display("FAIL ticlr_flag got=%b exp=0", csr_rvalue[11]); end
        csr_num = 14'h42; #1;
        total++;
        if (csr_rvalue !== 32'd0) begin bad++; $display("FAIL oneshot_hold got=%0d exp=0", csr_rvalue); end
    endtask

    task automatic test_timer_periodic();
        do_write(14'h41, 32'h0000_000B, 32'hFFFF_FFFF);
        csr_num = 14'h42; #1;
        total++;
        if (csr_rvalue !== 32'd8) begin bad++; $display("FAIL periodic_load got=%0d exp=8", csr_rvalue); end
        for (int i = 7; i >= 0; i--) begin
            tick();
            csr_num = 14'h42; #1;
            total++;
            if (csr_rvalue !== 32'(i)) begin bad++; $display("FAIL periodic_tval got=%0d exp=%0d", csr_rvalue, i); end
        end
        csr_num = 14'h5; #1;
        total++;
        if (csr_rvalue[11] !== 1'b1) begin bad++; $display("FAIL periodic_flag1 got=%b exp=1", csr_rvalue[11]); end
        tick();
        csr_num = 14'h42; #1;
        total++;
        if (csr_rvalue !== 32'd8) begin bad++; $display("FAIL periodic_reload got=%0d exp=8", csr_rvalue); end
        do_write(14'h44, 32'h1, 32'h1);
        csr_num = 14'h5; #1;
        total++;
        if (csr_rvalue[11] !== 1'b0) begin bad++; $display("FAIL periodic_clr got=%b exp=0", csr_rvalue[11]); end
        for (int i = 6; i >= 0; i--) tick();
        csr_num = 14'h42; #1;
        total++;
        if (csr_rvalue !== 32'd0) begin bad++; $display("FAIL periodic_tval2 got=%0d exp=0", csr_rvalue); end
        csr_num = 14'h5; #1;
        total++;
        if (csr_rvalue[11] !== 1'b1) begin bad++; $display("FAIL periodic_flag2 got=%b exp=1", csr_rvalue[11]); end
        do_write(14'h0, 32'h4, 32'hFFFF_FFFF);
        do_write(14'h4, 32'h800, 32'hFFFF_FFFF);
        total++;
        if (has_int !== 1'b1) begin bad++; $display("FAIL timer_has_int got=%b exp=1", has_int); end
    endtask

    task automatic test_hw_int_reset();
        do_write(14'h4, 32'h004, 32'hFFFF_FFFF);
        total++;
        if (has_int !== 1'b0) begin bad++; $display("FAIL hw_idle_has_int got=%b exp=0", has_int); end
        hw_int_in = 8'h01;
        #1;
        total++;
        if (has_int !== 1'b0) begin bad++; $display("FAIL hw_presample got=%b exp=0", has_int); end
        tick();
        total++;
        if (has_int !== 1'b1) begin bad++; $display("FAIL hw_has_int got=%b exp=1", has_int); end
        // Timer is still running periodically here; pull reset between edges.
        #1 resetn = 0;
        #1;
        csr_num = 14'h42; #1;
        total++;
        if (csr_rvalue !== 32'hFFFF_FFFF) begin bad++; $display("FAIL async_tval got=%h exp=ffffffff", csr_rvalue); end
        csr_num = 14'h0; #1;
        total++;
        if (csr_rvalue !== 32'h8) begin bad++; $display("FAIL async_crmd got=%h exp=8", csr_rvalue); end
        total++;
        if (has_int !== 1'b0) begin bad++; $display("FAIL async_has_int got=%b exp=0", has_int); end
        hw_int_in = 8'h00;
        model_reset();
        #1 resetn = 1;
    endtask

    task automatic test_random();
        logic [13:0] pool [18];
        logic [13:0] rnum;
        logic [31:0] exp;
        pool = '{14'h0, 14'h1, 14'h4, 14'h5, 14'h6, 14'h7, 14'hC, 14'h30, 14'h31,
                 14'h32, 14'h33, 14'h40, 14'h41, 14'h42, 14'h44, 14'h2, 14'h100, 14'h41};
        for (int i = 0; i < 600; i++) begin
            wb_ex       = ($urandom_range(0, 9) == 0);
            ertn_flush  = ($urandom_range(0, 7) == 0);
            wb_ecode    = ($urandom_range(0, 2) == 0) ? 6'h08 :
                          ($urandom_range(0, 1) == 0) ? 6'h09 : 6'($urandom);
            wb_esubcode = 9'($urandom);
            wb_pc       = $urandom;
            wb_vaddr    = $urandom;
            csr_we      = ($urandom_range(0, 1) == 1);
            csr_num     = pool[$urandom_range(0, 17)];
            csr_wmask   = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
            csr_wvalue  = $urandom;
            if (csr_num == 14'h41) csr_wvalue = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) hw_int_in = 8'($urandom);
            if ($urandom_range(0, 7) == 0) ipi_int_in = ~ipi_int_in;
            tick();
            rnum = pool[$urandom_range(0, 17)];
            csr_num = rnum; #1;
            exp = (rnum < 14'd128) ? m[rnum[6:0]] : 32'h0;
            total++;
            if (csr_rvalue !== exp) begin bad++; $display("FAIL rand_read csr=%0h got=%h exp=%h", rnum, csr_rvalue, exp); end
            csr_num = 14'h42; #1;
            total++;
            if (csr_rvalue !== m['h42]) begin bad++; $display("FAIL rand_tval got=%h exp=%h", csr_rvalue, m['h42]); end
            total++;
            if (has_int !== (m['h00][2] && ((m['h05][12:0] & m['h04][12:0]) != 0))) begin
                bad++; $display("FAIL rand_has_int got=%b", has_int);
            end
            total++;
            if (ex_entry !== m['h0C] || ertn_era !== m['h06]) begin
                bad++; $display("FAIL rand_outs entry=%h exp=%h era=%h exp=%h", ex_entry, m['h0C], ertn_era, m['h06]);
            end
        end
    endtask

    initial begin
        resetn = 0; csr_re = 1; csr_num = 0; csr_we = 0; csr_wmask = 0; csr_wvalue = 0;
        wb_ex = 0; wb_ecode = 0; wb_esubcode = 0; wb_pc = 0; wb_vaddr = 0;
        ertn_flush = 0; hw_int_in = 0; ipi_int_in = 0;
        model_reset();
        #22;
        test_reset();
        resetn = 1;
        test_eentry();
        test_ex_ertn();
        test_badv_priority();
        test_timer_oneshot();
        test_timer_periodic();
        test_hw_int_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
